alu_result_packer: RTL and testbench
====================================

# alu_result_packer

Consumer side of the ALU result path. Captures each registered ALU result (value plus valid flag, one-cycle strobe) and streams it to the UART transmitter as DATA_WIDTH-bit bytes, least-significant byte first. It uses the transmitter's data-valid/busy handshake. It sits between the ALU output registers and the UART TX in the system datapath.

## Interface
- DATA_WIDTH, 8, UART byte width
- RESULT_WIDTH, 16, ALU result width; must be an integer multiple of DATA_WIDTH (BYTES = RESULT_WIDTH/DATA_WIDTH, ≥1)
- BUSY_TIMEOUT, 15, cycles to wait for tx_busy to rise after a strobe before re-strobing
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- result_in  in  RESULT_WIDTH  ALU result, sampled when result_valid=1
- result_valid  in  1  one-cycle result strobe (ALU output flag)
- tx_busy  in  1  UART TX busy; high while a byte is being serialised
- tx_data  out  DATA_WIDTH  byte to transmit
- tx_data_valid  out  1  one-cycle strobe, tx_data valid
- packer_busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  one-cycle pulse: a result was dropped

## Operation
- FSM states: IDLE, STROBE, WAIT_HI, WAIT_LO.
- IDLE: on result_valid=1, load result_in into hold register, byte index ← 0, go to STROBE.
- STROBE: entered only when tx_busy=0; otherwise stay and do not strobe. When tx_busy=0, drive tx_data_valid=1 for one cycle with tx_data = hold[idx*DATA_WIDTH +: DATA_WIDTH], clear the timeout counter, go to WAIT_HI.
- WAIT_HI: on tx_busy=1 go to WAIT_LO. If the timeout counter reaches BUSY_TIMEOUT with no busy seen, return to STROBE and re-send the same byte. There is no retry limit.
- WAIT_LO: on tx_busy=0, if idx = BYTES-1 go to IDLE, else idx+1 and go to STROBE.
- tx_data holds its value between strobes and changes only at a strobe.
- result_valid in any state other than IDLE: handled per Configuration.
- Simultaneous result_valid and the final WAIT_LO→IDLE transition count as arrival while busy.

## Timing
- Reset (asynchronous assert, synchronous-release use): state=IDLE; tx_data=0, tx_data_valid=0, packer_busy=0, overrun=0; hold, idx, counter = 0.
- Reset mid-transfer aborts immediately. There is no partial-byte recovery. The skid entry is discarded.
- Latency: result_valid sampled at edge N → tx_data_valid high in cycle N+1 (STROBE, tx_busy=0).
- Each byte: strobe → ≥1 cycle WAIT_HI → WAIT_LO for the TX busy duration → next strobe one cycle after tx_busy falls.
- All outputs are registered. There is no combinational path from input to output.
- The timeout counter is $clog2(BUSY_TIMEOUT+1) bits wide and saturates at BUSY_TIMEOUT.

## Configuration
- ALU_PACKER_SKID_EN defined: one-entry skid register.
  - A result arriving while busy is stored.
  - In the cycle after returning to IDLE, the stored result is loaded as though freshly strobed.
  - overrun pulses only if a result arrives while the skid entry is already full. The new result is dropped and the skid entry is kept.
- Not defined: any result_valid while packer_busy=1 is dropped and overrun pulses in the following cycle.

## Structure
- Shared package: FSM state encoding (2-bit localparams IDLE=0, STROBE=1, WAIT_HI=2, WAIT_LO=3) and the BYTES derivation function, reused by the system controller.
- The module is flat. No sub-module is warranted; the byte mux is inline.

## Test plan
- Reset then idle: hold rst_n=0 mid-stream → all outputs 0 asynchronously. After release with no stimulus → tx_data_valid never asserts.
- Basic frame: result_in=16'hA55A strobed, TX model busy 10 cycles per byte → tx_data 8'h5A then 8'hA5, one strobe each, packer_busy falls after the second busy falls.
- Busy at start: tx_busy=1 when result_valid arrives → no strobe until tx_busy=0, then strobe in the next cycle.
- Timeout retry: TX model ignores the first strobe → after 15 cycles the same byte is re-strobed; after a normal busy cycle the frame completes.
- Overrun without ALU_PACKER_SKID_EN: second result 16'h1234 during a frame → overrun pulse, only the first result is transmitted.
- With ALU_PACKER_SKID_EN: results 16'h0001, 16'h0002, 16'h0003 back-to-back → 0001 and 0002 are sent in order, overrun pulses for 0003.

Source files
------------

// File: rtl/alu_result_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_result_packer_pkg
// Purpose : Shared definitions for the ALU result packer. Holds the 2-bit
//           FSM state encoding (also decoded by the system controller) and
//           the helper that derives how many UART bytes make up one result.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package alu_result_packer_pkg;

  // State encoding, kept as plain 2-bit constants so external logic can
  // decode the packer state without importing the enum type.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] STROBE  = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_STROBE  = STROBE,
    ST_WAIT_HI = WAIT_HI,
    ST_WAIT_LO = WAIT_LO
  } packer_state_e;

  // Number of DATA_WIDTH-bit bytes in one RESULT_WIDTH-bit result.
  function automatic int unsigned bytes_per_result(input int unsigned result_width,
                                                   input int unsigned data_width);
    return result_width / data_width;
  endfunction

endpackage : alu_result_packer_pkg
`default_nettype wire

// File: rtl/alu_result_packer.sv
`default_nettype none
// ============================================================================
// Module  : alu_result_packer
// Purpose : Captures each strobed ALU result and streams it to the UART
//           transmitter LSB byte first, using the TX data-valid/busy
//           handshake. A byte is re-sent if the transmitter never raises
//           busy within BUSY_TIMEOUT cycles.
// Ports   : clk           - clock, rising edge
//           rst_n         - asynchronous active-low reset
//           result_in     - ALU result, sampled when result_valid=1
//           result_valid  - one-cycle result strobe
//           tx_busy       - UART TX busy
//           tx_data       - byte to transmit (held between strobes)
//           tx_data_valid - one-cycle byte strobe
//           packer_busy   - high whenever the FSM is not idle
//           overrun       - one-cycle pulse when a result is dropped
// Config  : ALU_PACKER_SKID_EN - when defined, one result arriving while
//           busy is parked in a skid register and sent after the current
//           frame; otherwise every result arriving while busy is dropped.
// Revision: 1.0 - initial release
// ============================================================================
module alu_result_packer
  import alu_result_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = 16,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RESULT_WIDTH-1:0] result_in,
  input  logic                    result_valid,
  input  logic                    tx_busy,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_data_valid,
  output logic                    packer_busy,
  output logic                    overrun
);

  localparam int unsigned c_bytes = bytes_per_result(RESULT_WIDTH, DATA_WIDTH);
  localparam int unsigned c_idx_w = (c_bytes > 1) ? $clog2(c_bytes) : 1;
  localparam int unsigned c_cnt_w = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_bytes - 1);
  localparam logic [c_cnt_w-1:0] c_timeout  = c_cnt_w'(BUSY_TIMEOUT);

  packer_state_e             state_q, state_d;
  logic [RESULT_WIDTH-1:0]   hold_q, hold_d;
  logic [c_idx_w-1:0]        idx_q, idx_d;
  logic [c_cnt_w-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
  logic                      tx_valid_q, tx_valid_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;

`ifdef ALU_PACKER_SKID_EN
  logic [RESULT_WIDTH-1:0]   skid_q, skid_d;
  logic                      skid_full_q, skid_full_d;
`endif

  logic [RESULT_WIDTH-1:0]   w_shifted;
  logic [DATA_WIDTH-1:0]     w_byte;
  logic [c_cnt_w-1:0]        w_cnt_inc;

  // Byte selected by the current index, LSB byte at index 0.
  assign w_shifted = hold_q >> (int'(idx_q) * DATA_WIDTH);
  assign w_byte    = w_shifted[DATA_WIDTH-1:0];

  // Saturating increment of the busy-wait counter.
  assign w_cnt_inc = (cnt_q == c_timeout) ? cnt_q : cnt_q + c_cnt_w'(1);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    overrun_d  = 1'b0;
`ifdef ALU_PACKER_SKID_EN
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef ALU_PACKER_SKID_EN
        // A parked result takes priority; a result arriving in the same
        // cycle refills the skid slot that is being emptied.
        if (skid_full_q) begin
          hold_d      = skid_q;
          idx_d       = '0;
          state_d     = ST_STROBE;
          skid_full_d = 1'b0;
          if (result_valid) begin
            skid_d      = result_in;
            skid_full_d = 1'b1;
          end
        end else if (result_valid) begin
          hold_d  = result_in;
          idx_d   = '0;
          state_d = ST_STROBE;
        end
`else
        if (result_valid) begin
          hold_d  = result_in;
          idx_d   = '0;
          state_d = ST_STROBE;
        end
`endif
      end

      ST_STROBE: begin
        if (!tx_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = w_byte;
          cnt_d      = '0;
          state_d    = ST_WAIT_HI;
        end
      end

      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else begin
          cnt_d = w_cnt_inc;
          // Transmitter never acknowledged: resend the same byte.
          if (w_cnt_inc == c_timeout) begin
            state_d = ST_STROBE;
          end
        end
      end

      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == c_last_idx) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + c_idx_w'(1);
            state_d = ST_STROBE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Arrival while busy, including the cycle of the final WAIT_LO->IDLE step.
    if (result_valid && (state_q != ST_IDLE)) begin
`ifdef ALU_PACKER_SKID_EN
      if (skid_full_q) begin
        overrun_d = 1'b1;
      end else begin
        skid_d      = result_in;
        skid_full_d = 1'b1;
      end
`else
      overrun_d = 1'b1;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef ALU_PACKER_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else begin
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
    end
  end
`endif

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign packer_busy   = busy_q;
  assign overrun       = overrun_q;

endmodule : alu_result_packer
`default_nettype wire

// File: tb/tb_alu_result_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_result_packer
// Purpose : Self-checking bench for alu_result_packer. A transaction-level
//           model (queue of expected bytes plus a simple UART TX responder)
//           is compared against the DUT every cycle; directed scenarios add
//           hand-computed timing expectations.
// Config  : ALU_PACKER_SKID_EN selects the skid scenario instead of the
//           drop/overrun scenario.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_result_packer;

  localparam int unsigned DW       = 8;
  localparam int unsigned RW       = 16;
  localparam int unsigned TIMEOUT  = 15;
  localparam int          BUSY_LEN = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] result_in;
  logic          result_valid;
  logic          tx_busy = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_data_valid;
  logic          packer_busy;
  logic          overrun;

  alu_result_packer #(
    .DATA_WIDTH  (DW),
    .RESULT_WIDTH(RW),
    .BUSY_TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result_in    (result_in),
    .result_valid (result_valid),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .packer_busy  (packer_busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_byte = '0;
  bit            retry_pending = 0;
  int            busy_cnt = 0;
  bit            ext_busy = 0;
  int            ignore_next = 0;
  int            strobe_cyc[$];
  int            ovr_cyc[$];
  int            busy_fall_cyc = -1;
  logic          prev_pbusy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected bytes of one result, LSB first.
  task automatic expect_result(input logic [RW-1:0] v);
    for (int i = 0; i < RW / DW; i++) exp_q.push_back(v[i*DW +: DW]);
  endtask

  // Compare process and UART TX responder, both at the falling edge.
  initial begin : monitor
    logic [DW-1:0] exp_b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        last_byte     = '0;
        retry_pending = 0;
        busy_cnt      = 0;
        prev_pbusy    = 1'b0;
        tx_busy       = 1'b0;
      end else begin
        if (tx_data_valid) begin
          strobe_cyc.push_back(cyc);
          chk("strobe_while_busy", {31'd0, tx_busy}, 32'd0);
          exp_b = last_byte;
          if (retry_pending) begin
            exp_b = last_byte;
          end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got byte %0h expected no strobe (cycle %0d)", tx_data, cyc);
          end else begin
            exp_b = exp_q.pop_front();
          end
          chk("tx_data_strobe", {24'd0, tx_data}, {24'd0, exp_b});
          last_byte = exp_b;
          if (ignore_next > 0) begin
            ignore_next--;
            retry_pending = 1;
          end else begin
            retry_pending = 0;
            busy_cnt      = BUSY_LEN;
          end
        end else begin
          chk("tx_data_hold", {24'd0, tx_data}, {24'd0, last_byte});
          if (busy_cnt > 0) busy_cnt--;
        end
        if (overrun) ovr_cyc.push_back(cyc);
        if (prev_pbusy && !packer_busy) busy_fall_cyc = cyc;
        prev_pbusy = packer_busy;
        tx_busy    = (busy_cnt > 0) || ext_busy;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One-cycle result strobe; returns the cycle it was driven in.
  task automatic pulse(input logic [RW-1:0] v, output int c);
    result_in    = v;
    result_valid = 1'b1;
    c            = cyc;
    step();
    result_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || packer_busy || tx_busy) && n < 400) begin
      step();
      n++;
    end
    chk(name, {31'd0, (n < 400)}, 32'd1);
    repeat (3) step();
  endtask

  task automatic clear_log();
    strobe_cyc.delete();
    ovr_cyc.delete();
    busy_fall_cyc = -1;
  endtask

  initial begin : stim
    int c0, c1, c2, rel, n0;
    rst_n        = 1'b1;
    result_in    = '0;
    result_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("reset_tx_data",  {24'd0, tx_data}, 32'd0);
    chk("reset_valid",    {31'd0, tx_data_valid}, 32'd0);
    chk("reset_pbusy",    {31'd0, packer_busy}, 32'd0);
    chk("reset_overrun",  {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (20) step();
    chk("idle_no_strobe", strobe_cyc.size(), 32'd0);

    // Basic frame: 5A then A5, 10-cycle busy per byte.
    clear_log();
    expect_result(16'hA55A);
    pulse(16'hA55A, c0);
    chk("basic_pbusy_rise", {31'd0, packer_busy}, 32'd1);
    wait_idle("basic_done");
    chk("basic_strobes", strobe_cyc.size(), 32'd2);
    if (strobe_cyc.size() == 2) begin
      chk("basic_latency", strobe_cyc[0] - c0, 32'd2);
      chk("basic_gap",     strobe_cyc[1] - strobe_cyc[0], 32'd12);
      chk("basic_pbusy_fall", busy_fall_cyc - strobe_cyc[1], 32'd11);
    end

    // TX busy when the result arrives: first strobe waits for busy to drop.
    clear_log();
    expect_result(16'hC33C);
    ext_busy = 1;
    pulse(16'hC33C, c0);
    repeat (3) step();
    ext_busy = 0;
    rel = cyc;
    wait_idle("busy_start_done");
    chk("busy_start_strobes", strobe_cyc.size(), 32'd2);
    if (strobe_cyc.size() == 2)
      chk("busy_start_first", strobe_cyc[0] - rel, 32'd1);

    // Timeout retry: first strobe ignored, same byte re-sent.
    clear_log();
    expect_result(16'h7E81);
    ignore_next = 1;
    pulse(16'h7E81, c0);
    wait_idle("retry_done");
    chk("retry_strobes", strobe_cyc.size(), 32'd3);
    if (strobe_cyc.size() == 3)
      chk("retry_gap", strobe_cyc[1] - strobe_cyc[0], 32'd16);

`ifdef ALU_PACKER_SKID_EN
    // Three back-to-back results: two sent, third dropped.
    clear_log();
    expect_result(16'h0001);
    expect_result(16'h0002);
    pulse(16'h0001, c0);
    pulse(16'h0002, c1);
    pulse(16'h0003, c2);
    wait_idle("skid_done");
    chk("skid_strobes", strobe_cyc.size(), 32'd4);
    chk("skid_overruns", ovr_cyc.size(), 32'd1);
    if (ovr_cyc.size() == 1) chk("skid_overrun_cyc", ovr_cyc[0] - c2, 32'd1);
`else
    // Second result during a frame is dropped with an overrun pulse.
    clear_log();
    expect_result(16'hBEEF);
    pulse(16'hBEEF, c0);
    repeat (2) step();
    pulse(16'h1234, c1);
    wait_idle("overrun_done");
    repeat (10) step();
    chk("overrun_strobes", strobe_cyc.size(), 32'd2);
    chk("overrun_count", ovr_cyc.size(), 32'd1);
    if (ovr_cyc.size() == 1) chk("overrun_cyc", ovr_cyc[0] - c1, 32'd1);
`endif

    // Reset in the middle of a frame aborts it immediately.
    clear_log();
    expect_result(16'h66A5);
    pulse(16'h66A5, c0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midreset_tx_data", {24'd0, tx_data}, 32'd0);
    chk("midreset_valid",   {31'd0, tx_data_valid}, 32'd0);
    chk("midreset_pbusy",   {31'd0, packer_busy}, 32'd0);
    chk("midreset_overrun", {31'd0, overrun}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    n0 = strobe_cyc.size();
    repeat (20) step();
    chk("midreset_no_strobe", strobe_cyc.size() - n0, 32'd0);
    chk("midreset_idle", {31'd0, packer_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu_result_packer
`default_nettype wire
